uart_alu_interface: RTL
=======================

// Module: uart_alu_interface
// PURPOSE
//  Responder between the UART receiver/transmitter pair and the ALU inside uart_alu_top.
//  Collects a 3-byte command from the RX byte stream (opcode, operand A, operand B) and
//  drives the latched operands to the ALU. Captures the ALU result and hands it to the
//  UART TX as one byte. Answers the host-side byte stream the top-level bench drives on i_rx.
// PARAMETERS
//  DATA_WIDTH  8  width of RX/TX bytes, operands and ALU result
//  OP_WIDTH    6  width of o_alu_op (low bits of the opcode byte)
// PORTS
//  i_clk          in   1           system clock, rising edge
//  i_reset        in   1           asynchronous, active-low reset
//  i_rx_done      in   1           1-cycle pulse: i_rx_data holds a new received byte
//  i_rx_data      in   DATA_WIDTH  received byte
//  i_tx_done      in   1           1-cycle pulse: UART TX finished sending the last byte
//  i_alu_result   in   DATA_WIDTH  combinational ALU result for o_alu_op/a/b
//  o_alu_op       out  OP_WIDTH    latched opcode = opcode_byte[OP_WIDTH-1:0]
//  o_alu_a        out  DATA_WIDTH  latched operand A
//  o_alu_b        out  DATA_WIDTH  latched operand B
//  o_tx_start     out  1           1-cycle pulse: start UART transmission of o_tx_data
//  o_tx_data      out  DATA_WIDTH  byte to transmit (ALU result), stable until i_tx_done
//  o_busy         out  1           high in EXEC and WAIT_TX
//  o_op_err       out  1           1-cycle pulse: invalid opcode byte was rejected
//  o_rx_overrun   out  1           1-cycle pulse: byte arrived in EXEC/WAIT_TX and was dropped
// BEHAVIOUR
//  Reset (i_reset=0, async): state=WAIT_OP. All outputs and internal registers are 0.
//  Valid opcodes (full 8-bit compare): 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR,
//    0x03 SRA, 0x02 SRL, 0x27 NOR.
//  FSM states: WAIT_OP, WAIT_A, WAIT_B, EXEC, WAIT_TX. All transitions on rising i_clk.
//  WAIT_OP: on i_rx_done, if byte valid -> latch o_alu_op, go WAIT_A.
//    If byte invalid -> o_op_err=1 next cycle, o_alu_op unchanged, stay in WAIT_OP.
//  WAIT_A: on i_rx_done -> latch o_alu_a, go WAIT_B. No timeout; wait indefinitely.
//  WAIT_B: on i_rx_done -> latch o_alu_b, go EXEC.
//  EXEC: exactly 1 cycle; ALU settles on the new operands.
//    On exit register o_tx_data<=i_alu_result and o_tx_start<=1, go WAIT_TX.
//  WAIT_TX: o_tx_start is high only in the first cycle. On i_tx_done -> WAIT_OP.
//  Latency: B-byte i_rx_done sampled at edge k -> o_tx_start high between edges k+2 and k+3.
//  Operands and opcode hold their values until overwritten by the next command.
//  o_tx_data holds until the next EXEC.
//  i_rx_done in EXEC or WAIT_TX: byte discarded, o_rx_overrun pulses for 1 cycle.
//    The command in progress is unaffected.
//  Simultaneous i_tx_done and i_rx_done in WAIT_TX: go WAIT_OP, byte dropped, o_rx_overrun=1.
//  i_tx_done outside WAIT_TX: ignored.
//  Pulse outputs (o_tx_start, o_op_err, o_rx_overrun) are registered and last exactly 1 cycle.
//  Reset asserted mid-command: command aborted, state=WAIT_OP, partial operands cleared to 0.
//  No arithmetic in this block; widths pass through unchanged, no truncation or extension.
// TESTING
//  1. RX 0x20,0x05,0x03 with an ALU model -> o_alu_op=0x20, a=0x05, b=0x03, o_tx_data=0x08,
//     single o_tx_start pulse 2 cycles after the B byte.
//  2. RX 0xFF -> o_op_err 1-cycle pulse, state stays WAIT_OP.
//     Then 0x22,0x09,0x04 -> o_tx_data=0x05.
//  3. RX 0x03,0xF0,0x02 (SRA) -> o_tx_data=0xFC. Hold i_tx_done low 100 cycles:
//     o_busy stays high, no second o_tx_start.
//  4. RX byte 0x55 while in WAIT_TX -> o_rx_overrun pulse, operands unchanged.
//     Assert i_rx_done and i_tx_done in the same cycle -> WAIT_OP, o_rx_overrun pulse.
//  5. RX 0x24,0xAA, then drop i_reset low for 3 cycles -> all outputs 0, state WAIT_OP.
//     Full command 0x25,0xA0,0x0F -> o_tx_data=0xAF.
//  6. Full bit-serial loop through uart_alu_top at 19200 baud, 50 MHz:
//     send 0x27,0x0F,0xF0 on i_rx -> o_tx serialises 0x00 (NOR).

Source files
------------

// File: rtl/uart_alu_interface.sv
// -----------------------------------------------------------------------------
// uart_alu_interface
//  Collects a 3-byte command (opcode, operand A, operand B) from the UART RX
//  byte stream, presents the latched operands to the ALU, captures the ALU
//  result and starts a single-byte UART TX transfer with it.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  WAIT_OP | idle, waiting for an opcode byte (invalid ones are rejected)
//  WAIT_A  | opcode latched, waiting for operand A
//  WAIT_B  | operand A latched, waiting for operand B
//  EXEC    | one cycle for the ALU to settle on the new operands
//  WAIT_TX | result captured, TX started, waiting for i_tx_done
//
// Ports
//  i_clk, i_reset            clock (rising edge), async active-low reset
//  i_rx_done, i_rx_data      received-byte strobe and byte
//  i_tx_done                 TX finished strobe
//  i_alu_result              combinational ALU result
//  o_alu_op, o_alu_a, o_alu_b  latched command to the ALU
//  o_tx_start, o_tx_data     TX start pulse and byte to send
//  o_busy                    high in EXEC and WAIT_TX
//  o_op_err, o_rx_overrun    error pulses (invalid opcode, dropped byte)
// -----------------------------------------------------------------------------
module uart_alu_interface #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 6
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_rx_done,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic                  i_tx_done,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   output logic [OP_WIDTH-1:0]   o_alu_op,
   output logic [DATA_WIDTH-1:0] o_alu_a,
   output logic [DATA_WIDTH-1:0] o_alu_b,
   output logic                  o_tx_start,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic                  o_busy,
   output logic                  o_op_err,
   output logic                  o_rx_overrun
);

   typedef enum logic [2:0] {
      S_WAIT_OP = 3'd0,
      S_WAIT_A  = 3'd1,
      S_WAIT_B  = 3'd2,
      S_EXEC    = 3'd3,
      S_WAIT_TX = 3'd4
   } state_t;

   localparam logic [DATA_WIDTH-1:0] OPC_ADD = DATA_WIDTH'(8'h20);
   localparam logic [DATA_WIDTH-1:0] OPC_SUB = DATA_WIDTH'(8'h22);
   localparam logic [DATA_WIDTH-1:0] OPC_AND = DATA_WIDTH'(8'h24);
   localparam logic [DATA_WIDTH-1:0] OPC_OR  = DATA_WIDTH'(8'h25);
   localparam logic [DATA_WIDTH-1:0] OPC_XOR = DATA_WIDTH'(8'h26);
   localparam logic [DATA_WIDTH-1:0] OPC_SRA = DATA_WIDTH'(8'h03);
   localparam logic [DATA_WIDTH-1:0] OPC_SRL = DATA_WIDTH'(8'h02);
   localparam logic [DATA_WIDTH-1:0] OPC_NOR = DATA_WIDTH'(8'h27);

   state_t state, state_nxt;
   logic   op_valid;
   logic   load_op, load_a, load_b, load_res;
   logic   op_err_nxt, overrun_nxt;
   logic   exec_d;

   // Full-byte compare: an opcode whose low bits alias a valid one is still rejected.
   always_comb begin
      op_valid = 1'b0;
      case (i_rx_data)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
         OPC_XOR, OPC_SRA, OPC_SRL, OPC_NOR: op_valid = 1'b1;
         default:                            op_valid = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state <= S_WAIT_OP;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT_OP: if (i_rx_done && op_valid) state_nxt = S_WAIT_A;
         S_WAIT_A:  if (i_rx_done)             state_nxt = S_WAIT_B;
         S_WAIT_B:  if (i_rx_done)             state_nxt = S_EXEC;
         S_EXEC:                               state_nxt = S_WAIT_TX;
         S_WAIT_TX: if (i_tx_done)             state_nxt = S_WAIT_OP;
         default:                              state_nxt = S_WAIT_OP;
      endcase
   end

   always_comb begin
      load_op     = 1'b0;
      load_a      = 1'b0;
      load_b      = 1'b0;
      load_res    = 1'b0;
      op_err_nxt  = 1'b0;
      overrun_nxt = 1'b0;
      o_busy      = 1'b0;
      case (state)
         S_WAIT_OP: begin
            load_op    = i_rx_done && op_valid;
            op_err_nxt = i_rx_done && !op_valid;
         end
         S_WAIT_A: load_a = i_rx_done;
         S_WAIT_B: load_b = i_rx_done;
         S_EXEC: begin
            load_res    = 1'b1;
            overrun_nxt = i_rx_done;
            o_busy      = 1'b1;
         end
         S_WAIT_TX: begin
            overrun_nxt = i_rx_done;
            o_busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // The start pulse trails the result capture by one cycle so o_tx_data is
   // already stable when the transmitter sees the strobe; this places the pulse
   // two cycles after the edge that samples the B byte.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_alu_op     <= '0;
         o_alu_a      <= '0;
         o_alu_b      <= '0;
         o_tx_data    <= '0;
         o_tx_start   <= 1'b0;
         o_op_err     <= 1'b0;
         o_rx_overrun <= 1'b0;
         exec_d       <= 1'b0;
      end else begin
         if (load_op)  o_alu_op  <= i_rx_data[OP_WIDTH-1:0];
         if (load_a)   o_alu_a   <= i_rx_data;
         if (load_b)   o_alu_b   <= i_rx_data;
         if (load_res) o_tx_data <= i_alu_result;
         exec_d       <= load_res;
         o_tx_start   <= exec_d;
         o_op_err     <= op_err_nxt;
         o_rx_overrun <= overrun_nxt;
      end
   end

endmodule
